// File: rtl/hiscore_pkg.sv
// Shared types and constants for the hiscore work-RAM arbiter.
package hiscore_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    SETTLE,
    GRANT,
    DRAIN,
    GAP
  } arb_state_t;

  localparam logic SEL_GAME = 1'b0;
  localparam logic SEL_HS   = 1'b1;

  localparam int unsigned CNT_W = 16;
  typedef logic [CNT_W-1:0] cnt_t;

  // A phase of N cycles loads N-1 so the exit fires on the Nth cycle.
  function automatic cnt_t cnt_load(input int unsigned cycles);
    return (cycles == 0) ? '0 : cnt_t'(cycles - 1);
  endfunction

endpackage

// File: rtl/hiscore_ram_mux.sv
// Registered 2:1 work-RAM source mux (CPU or hiscore engine) with write gating.
module hiscore_ram_mux
  import hiscore_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sel,
  input  logic                  hs_we_en,
  input  logic [ADDR_WIDTH-1:0] hs_address,
  input  logic [7:0]            hs_data,
  input  logic                  hs_write,
  input  logic [ADDR_WIDTH-1:0] game_address,
  input  logic [7:0]            game_data,
  input  logic                  game_we,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [7:0]            ram_data,
  output logic                  ram_we
);

  always_ff @(posedge clk) begin
    if (reset) begin
      ram_address <= '0;
      ram_data    <= '0;
      ram_we      <= 1'b0;
    end else if (sel == SEL_HS) begin
      ram_address <= hs_address;
      ram_data    <= hs_data;
      ram_we      <= hs_write & hs_we_en;
    end else begin
      ram_address <= game_address;
      ram_data    <= game_data;
      ram_we      <= game_we;
    end
  end

endmodule

// File: rtl/hiscore_ram_arbiter.sv
// Arbitrates the game work-RAM port between the CPU and the hiscore engine,
// pausing the CPU via pause_req/pause_ack around each engine access window.
module hiscore_ram_arbiter
  import hiscore_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 10,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned DRAIN_CYCLES  = 2,
  parameter int unsigned GAP_CYCLES    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hs_access,
  input  logic                  hs_write,
  input  logic [ADDR_WIDTH-1:0] hs_address,
  input  logic [7:0]            hs_data,
  output logic                  hs_ready,
  output logic [7:0]            hs_q,
  input  logic [ADDR_WIDTH-1:0] game_address,
  input  logic [7:0]            game_data,
  input  logic                  game_we,
  output logic                  pause_req,
  input  logic                  pause_ack,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [7:0]            ram_data,
  output logic                  ram_we,
  input  logic [7:0]            ram_q,
  output logic                  busy
);

  localparam cnt_t SETTLE_LOAD = cnt_load(SETTLE_CYCLES);
  localparam cnt_t DRAIN_LOAD  = cnt_load(DRAIN_CYCLES);
  localparam cnt_t GAP_LOAD    = cnt_load(GAP_CYCLES);

  arb_state_t state, state_nx;
  cnt_t       cnt, cnt_nx;
  logic       sel;
  logic       hs_we_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = (cnt == '0) ? '0 : cnt - cnt_t'(1);
    sel       = SEL_GAME;
    hs_we_en  = 1'b0;
    pause_req = 1'b0;
    hs_ready  = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (hs_access) state_nx = REQ;
      end
      REQ: begin
        pause_req = 1'b1;
        // A release in the same cycle as the ack aborts without a grant.
        if (!hs_access) begin
          state_nx = IDLE;
        end else if (pause_ack) begin
          state_nx = SETTLE;
          cnt_nx   = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        pause_req = 1'b1;
        if (!pause_ack)      state_nx = REQ;
        else if (cnt == '0)  state_nx = GRANT;
      end
      GRANT: begin
        pause_req = 1'b1;
        hs_ready  = 1'b1;
        sel       = SEL_HS;
        // An engine write is only passed while the CPU is still halted.
        hs_we_en  = pause_ack;
        if (!hs_access) begin
          state_nx = DRAIN;
          cnt_nx   = DRAIN_LOAD;
        end else if (!pause_ack) begin
          state_nx = REQ;
        end
      end
      DRAIN: begin
        pause_req = 1'b1;
        sel       = SEL_HS;
        if (cnt == '0) begin
          state_nx = (GAP_CYCLES == 0) ? IDLE : GAP;
          cnt_nx   = GAP_LOAD;
        end
      end
      GAP: begin
        if (cnt == '0) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  hiscore_ram_mux #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mux (
    .clk          (clk),
    .reset        (reset),
    .sel          (sel),
    .hs_we_en     (hs_we_en),
    .hs_address   (hs_address),
    .hs_data      (hs_data),
    .hs_write     (hs_write),
    .game_address (game_address),
    .game_data    (game_data),
    .game_we      (game_we),
    .ram_address  (ram_address),
    .ram_data     (ram_data),
    .ram_we       (ram_we)
  );

  always_ff @(posedge clk) begin
    if (reset)              hs_q <= '0;
    else if (sel == SEL_HS) hs_q <= ram_q;
  end

endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
// Self-checking bench for hiscore_ram_arbiter with a registered RAM model and
// a CPU whose pause_ack follows pause_req by one cycle.
module tb_hiscore_ram_arbiter;

  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          hs_access = 1'b0;
  logic          hs_write = 1'b0;
  logic [AW-1:0] hs_address = '0;
  logic [7:0]    hs_data = '0;
  logic          hs_ready;
  logic [7:0]    hs_q;
  logic [AW-1:0] game_address = '0;
  logic [7:0]    game_data = '0;
  logic          game_we = 1'b0;
  logic          pause_req;
  logic          pause_ack;
  logic [AW-1:0] ram_address;
  logic [7:0]    ram_data;
  logic          ram_we;
  logic [7:0]    ram_q;
  logic          busy;

  logic          ack_q = 1'b0;
  logic          ack_en = 1'b1;
  logic          clr_mem = 1'b1;
  logic [7:0]    mem [0:(1<<AW)-1];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  hiscore_ram_arbiter #(
    .ADDR_WIDTH(AW),
    .SETTLE_CYCLES(4),
    .DRAIN_CYCLES(2),
    .GAP_CYCLES(64)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .hs_access    (hs_access),
    .hs_write     (hs_write),
    .hs_address   (hs_address),
    .hs_data      (hs_data),
    .hs_ready     (hs_ready),
    .hs_q         (hs_q),
    .game_address (game_address),
    .game_data    (game_data),
    .game_we      (game_we),
    .pause_req    (pause_req),
    .pause_ack    (pause_ack),
    .ram_address  (ram_address),
    .ram_data     (ram_data),
    .ram_we       (ram_we),
    .ram_q        (ram_q),
    .busy         (busy)
  );

  always @(posedge clk) ack_q <= pause_req;
  assign pause_ack = ack_q & ack_en;

  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= 8'h00;
    end else if (ram_we) begin
      mem[ram_address] <= ram_data;
    end
    ram_q <= mem[ram_address];
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
    logic          we;
  } bus_t;

  typedef struct {
    logic          hs_write;
    logic [AW-1:0] hs_addr;
    logic [7:0]    hs_data;
    logic [AW-1:0] g_addr;
    logic [7:0]    g_data;
    logic          g_we;
    logic [AW-1:0] e_addr;
    logic [7:0]    e_data;
    logic          e_we;
  } vec_t;

  bus_t exp_q[$];
  vec_t vecs[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic tick_expect(input string nm, input logic [AW-1:0] a,
                             input logic [7:0] d, input logic w);
    bus_t e;
    exp_q.push_back('{a, d, w});
    step();
    if (exp_q.size() == 0) begin
      check({nm, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({nm, "_addr"}, 32'(ram_address), 32'(e.addr));
      check({nm, "_data"}, 32'(ram_data), 32'(e.data));
      check({nm, "_we"}, 32'(ram_we), 32'(e.we));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    vecs[0] = '{1'b1, 10'h3AA, 8'h11, 10'h040, 8'hA7, 1'b1, 10'h040, 8'hA7, 1'b1};
    vecs[1] = '{1'b0, 10'h000, 8'h00, 10'h001, 8'h00, 1'b0, 10'h001, 8'h00, 1'b0};
    vecs[2] = '{1'b1, 10'h123, 8'hCC, 10'h2FF, 8'hFF, 1'b1, 10'h2FF, 8'hFF, 1'b1};
    vecs[3] = '{1'b1, 10'h055, 8'hEE, 10'h200, 8'h5C, 1'b0, 10'h200, 8'h5C, 1'b0};
    vecs[4] = '{1'b0, 10'h3FF, 8'h99, 10'h155, 8'hAA, 1'b1, 10'h155, 8'hAA, 1'b1};
    vecs[5] = '{1'b1, 10'h040, 8'h01, 10'h000, 8'h00, 1'b0, 10'h000, 8'h00, 1'b0};

    step();
    step();
    check("rst_pause_req", 32'(pause_req), 0);
    check("rst_hs_ready", 32'(hs_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ram_we", 32'(ram_we), 0);
    check("rst_ram_address", 32'(ram_address), 0);
    check("rst_ram_data", 32'(ram_data), 0);
    check("rst_hs_q", 32'(hs_q), 0);
    reset = 1'b0;
    clr_mem = 1'b0;

    // CPU passthrough in IDLE; engine write strobe must be ignored
    for (int i = 0; i < 6; i++) begin
      hs_write     = vecs[i].hs_write;
      hs_address   = vecs[i].hs_addr;
      hs_data      = vecs[i].hs_data;
      game_address = vecs[i].g_addr;
      game_data    = vecs[i].g_data;
      game_we      = vecs[i].g_we;
      tick_expect($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_data, vecs[i].e_we);
      check($sformatf("vec%0d_busy", i), 32'(busy), 0);
    end
    hs_write = 1'b0;
    game_we  = 1'b0;
    step();
    check("idle_hs_q_held", 32'(hs_q), 0);
    check("mem_040_by_cpu", 32'(mem[10'h040]), 32'h0A7);

    // Basic grant
    hs_access = 1'b1;
    step();
    check("grant_pause_req_n1", 32'(pause_req), 1);
    check("grant_busy_n1", 32'(busy), 1);
    check("grant_ready_n1", 32'(hs_ready), 0);
    n = 1;
    while (!hs_ready && n < 30) begin
      step();
      n++;
    end
    check("grant_latency", n, 7);

    // Engine write with concurrent CPU write attempts
    hs_address   = 10'h123;
    hs_data      = 8'h5A;
    hs_write     = 1'b1;
    game_address = 10'h055;
    game_data    = 8'hEE;
    game_we      = 1'b1;
    tick_expect("wr1", 10'h123, 8'h5A, 1'b1);
    tick_expect("wr2", 10'h123, 8'h5A, 1'b1);
    hs_write = 1'b0;
    tick_expect("wr_end", 10'h123, 8'h5A, 1'b0);

    // Engine read: address at r, hs_q at r+3
    hs_address = 10'h040;
    game_we    = 1'b0;
    tick_expect("rd_addr", 10'h040, 8'h5A, 1'b0);
    step();
    check("rd_hs_q_r2", 32'(hs_q), 32'h05A);
    step();
    check("rd_hs_q_r3", 32'(hs_q), 32'h0A7);
    check("mem_123", 32'(mem[10'h123]), 32'h05A);
    check("mem_055_blocked", 32'(mem[10'h055]), 0);

    // Ack loss with a pending engine write
    hs_address = 10'h200;
    hs_data    = 8'h33;
    hs_write   = 1'b1;
    ack_en     = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      check($sformatf("ackloss%0d_ready", i), 32'(hs_ready), 0);
      check($sformatf("ackloss%0d_we", i), 32'(ram_we), 0);
      check($sformatf("ackloss%0d_pause", i), 32'(pause_req), 1);
    end
    ack_en   = 1'b1;
    hs_write = 1'b0;
    n = 0;
    while (!hs_ready && n < 30) begin
      step();
      n++;
    end
    check("regrant_latency", n, 5);
    check("mem_200_no_write", 32'(mem[10'h200]), 0);

    // Release, drain, gap
    hs_access = 1'b0;
    step();
    check("rel_ready_f1", 32'(hs_ready), 0);
    check("rel_pause_f1", 32'(pause_req), 1);
    step();
    check("rel_pause_f2", 32'(pause_req), 1);
    step();
    check("rel_pause_f3", 32'(pause_req), 0);
    check("gap_busy", 32'(busy), 1);
    hs_access    = 1'b1;
    game_address = 10'h300;
    game_data    = 8'h77;
    game_we      = 1'b1;
    tick_expect("gap_cpu_wr", 10'h300, 8'h77, 1'b1);
    game_we = 1'b0;
    n = 4;
    while (!pause_req && n < 200) begin
      step();
      n++;
    end
    check("gap_repause_cycle", n, 68);
    check("mem_300_gap_write", 32'(mem[10'h300]), 32'h077);

    // Reset mid-GRANT with an engine write
    n = 0;
    while (!hs_ready && n < 30) begin
      step();
      n++;
    end
    check("grant3_ready", 32'(hs_ready), 1);
    hs_address = 10'h040;
    step();
    step();
    step();
    check("grant3_hs_q", 32'(hs_q), 32'h0A7);
    hs_address = 10'h3FF;
    hs_data    = 8'h99;
    hs_write   = 1'b1;
    reset      = 1'b1;
    step();
    check("midrst_ram_we", 32'(ram_we), 0);
    check("midrst_pause_req", 32'(pause_req), 0);
    check("midrst_hs_ready", 32'(hs_ready), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_hs_q", 32'(hs_q), 0);
    check("midrst_ram_address", 32'(ram_address), 0);
    reset     = 1'b0;
    hs_access = 1'b0;
    hs_write  = 1'b0;
    step();
    check("postrst_busy", 32'(busy), 0);
    step();
    check("mem_3ff_dropped", 32'(mem[10'h3FF]), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
